// File: rtl/alu_exec_if.sv
// Handshake and operand bus between the execute-stage requester and alu_exec.
interface alu_exec_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        Funct;
  logic [DATA_W-1:0] Src_1;
  logic [DATA_W-1:0] Src_2;
  logic [4:0]        Shamt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic              illegal;

  // Requester side: issues operations, observes status and result.
  modport master (
    output start, Funct, Src_1, Src_2, Shamt,
    input  busy, done, Result, Zero, illegal
  );

  // Execution unit side.
  modport slave (
    input  start, Funct, Src_1, Src_2, Shamt,
    output busy, done, Result, Zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Multi-cycle ALU execution unit: addu/subu/AND finish in one cycle,
// sll shifts one bit position per cycle from the captured source.
module alu_exec #(
  parameter int DATA_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_AND  = 6'b010001;
  localparam logic [5:0] F_SLL  = 6'b100001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [DATA_W-1:0] acc_reg;
  logic [4:0]        cnt_reg;
  logic [DATA_W-1:0] result_reg;
  logic              illegal_reg;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode: only sll visits SHIFT, everything else goes straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.Funct == F_SLL) state_next = SHIFT;
          else                    state_next = DONE;
        end
      end
      SHIFT:   if (cnt_reg == 5'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: single-cycle ops write Result at acceptance; sll iterates on acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            illegal_reg <= 1'b0;
            case (bus.Funct)
              F_ADDU: result_reg <= bus.Src_1 + bus.Src_2;
              F_SUBU: result_reg <= bus.Src_1 - bus.Src_2;
              F_AND:  result_reg <= bus.Src_1 & bus.Src_2;
              F_SLL: begin
                // Result keeps its old value until the shift completes.
                acc_reg <= bus.Src_1;
                cnt_reg <= bus.Shamt;
              end
              default: begin
                result_reg  <= '0;
                illegal_reg <= 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt_reg == 5'd0) begin
            result_reg <= acc_reg;
          end else begin
            acc_reg <= {acc_reg[DATA_W-2:0], 1'b0};
            cnt_reg <= cnt_reg - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_reg == SHIFT);
  assign bus.done    = (state_reg == DONE);
  assign bus.Result  = result_reg;
  assign bus.Zero    = (result_reg == '0);
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec: one task per scenario, inline checks.
module tb_alu_exec;

  localparam logic [5:0] F_ADDU = 6'b001001;
  localparam logic [5:0] F_SUBU = 6'b001010;
  localparam logic [5:0] F_AND  = 6'b010001;
  localparam logic [5:0] F_SLL  = 6'b100001;
  localparam logic [5:0] F_BAD  = 6'b001011;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_exec_if #(.DATA_W(32)) bus ();

  alu_exec #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation before a rising edge and drop start right after it.
  // On return we sit #1 after the acceptance edge E0.
  task automatic issue(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Funct = f;
    bus.Src_1 = a;
    bus.Src_2 = b;
    bus.Shamt = sh;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.Funct = 6'h3f;
    bus.Src_1 = 32'hdead_beef;
    bus.Src_2 = 32'hcafe_f00d;
    bus.Shamt = 5'd7;
  endtask

  // Count cycles from E0 until done is seen (latency) and busy samples.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full transaction: issue, wait, check latency/result/zero/illegal, settle into IDLE.
  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input int exp_lat,
                        input int exp_busy, input logic [31:0] exp_res,
                        input logic exp_ill);
    int lat;
    int bc;
    issue(f, a, b, sh);
    wait_done(lat, bc);
    $display("op %s funct=%b a=%h b=%h sh=%0d -> result=%h zero=%b illegal=%b lat=%0d busy=%0d",
             name, f, a, b, sh, bus.Result, bus.Zero, bus.illegal, lat, bc);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    total++;
    if (bc !== exp_busy) begin
      bad++;
      $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bc, exp_busy);
    end
    total++;
    if (bus.Result !== exp_res) begin
      bad++;
      $display("FAIL %s_result got=%h want=%h", name, bus.Result, exp_res);
    end
    total++;
    if (bus.Zero !== (exp_res == 32'd0)) begin
      bad++;
      $display("FAIL %s_zero got=%b want=%b", name, bus.Zero, (exp_res == 32'd0));
    end
    total++;
    if (bus.illegal !== exp_ill) begin
      bad++;
      $display("FAIL %s_illegal got=%b want=%b", name, bus.illegal, exp_ill);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse_width got=%b want=0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    int unstable;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    $display("reset: result=%h zero=%b busy=%b done=%b illegal=%b",
             bus.Result, bus.Zero, bus.busy, bus.done, bus.illegal);
    total++;
    if ({bus.Result, bus.Zero, bus.busy, bus.done, bus.illegal} !== {32'd0, 1'b1, 3'b000}) begin
      bad++;
      $display("FAIL reset_values got=%h/%b%b%b%b want=00000000/1000",
               bus.Result, bus.Zero, bus.busy, bus.done, bus.illegal);
    end
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if ({bus.Result, bus.Zero, bus.busy, bus.done, bus.illegal} !== {32'd0, 1'b1, 3'b000})
        unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL reset_idle_stable got=%0d_bad_cycles want=0", unstable);
    end
  endtask

  task automatic test_addu();
    run_op("addu_wrap", F_ADDU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1, 0, 32'h0000_0000, 1'b0);
    run_op("addu", F_ADDU, 32'h1234_5678, 32'h1111_1111, 5'd0, 1, 0, 32'h2345_6789, 1'b0);
  endtask

  task automatic test_subu_and();
    run_op("subu", F_SUBU, 32'd5, 32'd7, 5'd0, 1, 0, 32'hFFFF_FFFE, 1'b0);
    run_op("and", F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 1, 0, 32'h00F0_00F0, 1'b0);
  endtask

  task automatic test_sll();
    run_op("sll31", F_SLL, 32'h0000_0001, 32'h0, 5'd31, 33, 32, 32'h8000_0000, 1'b0);
    run_op("sll0", F_SLL, 32'h0000_1234, 32'hFFFF, 5'd0, 2, 1, 32'h0000_1234, 1'b0);
    run_op("sll4", F_SLL, 32'hF000_00A5, 32'h0, 5'd4, 6, 5, 32'h0000_0A50, 1'b0);
  endtask

  task automatic test_busy_illegal();
    int lat;
    int bc;
    issue(F_SLL, 32'h0000_0003, 32'h0, 5'd10);
    // Mid-shift, a start with addu must be ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.Funct = F_ADDU;
    bus.Src_1 = 32'd1;
    bus.Src_2 = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    total++;
    if (bus.Result !== 32'h0000_0A50) begin
      bad++;
      $display("FAIL busy_result_held got=%h want=00000a50", bus.Result);
    end
    wait_done(lat, bc);
    $display("op sll_busy_ignore -> result=%h lat_after_pulse=%0d", bus.Result, lat);
    total++;
    if (bus.Result !== 32'h0000_0C00) begin
      bad++;
      $display("FAIL busy_ignore_result got=%h want=00000c00", bus.Result);
    end
    @(posedge clk);
    #1;
    run_op("illegal", F_BAD, 32'h1, 32'h2, 5'd0, 1, 0, 32'h0, 1'b1);
    run_op("legal_clears", F_AND, 32'hFF, 32'h0F, 5'd0, 1, 0, 32'h0000_000F, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(F_ADDU, 32'd1, 32'd2, 5'd0);
    // Hold start through DONE with a different op; it is only taken at E0+2.
    bus.start = 1'b1;
    bus.Funct = F_SUBU;
    bus.Src_1 = 32'd10;
    bus.Src_2 = 32'd3;
    total++;
    if (bus.done !== 1'b1 || bus.Result !== 32'd3) begin
      bad++;
      $display("FAIL b2b_first got=%b/%h want=1/00000003", bus.done, bus.Result);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.Result !== 32'd3) begin
      bad++;
      $display("FAIL b2b_ignored_in_done got=%b/%h want=0/00000003", bus.done, bus.Result);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    $display("op b2b second -> result=%h done=%b", bus.Result, bus.done);
    total++;
    if (bus.done !== 1'b1 || bus.Result !== 32'd7) begin
      bad++;
      $display("FAIL b2b_second got=%b/%h want=1/00000007", bus.done, bus.Result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_shift();
    int done_seen;
    run_op("pre", F_ADDU, 32'h1234, 32'h0, 5'd0, 1, 0, 32'h0000_1234, 1'b0);
    issue(F_SLL, 32'h0000_0001, 32'h0, 5'd20);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("reset mid-shift: result=%h busy=%b zero=%b", bus.Result, bus.busy, bus.Zero);
    total++;
    if (bus.Result !== 32'd0 || bus.busy !== 1'b0 || bus.Zero !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_shift got=%h/%b/%b want=00000000/0/1", bus.Result, bus.busy, bus.Zero);
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL rst_no_done got=%0d_active_cycles want=0", done_seen);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.start = 1'b0;
    bus.Funct = 6'd0;
    bus.Src_1 = '0;
    bus.Src_2 = '0;
    bus.Shamt = '0;
    rst = 1'b0;
    test_reset();
    test_addu();
    test_subu_and();
    test_sll();
    test_busy_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
